// File: rtl/rom_seq_pkg.sv
// Shared defaults and FSM state encoding for the sequential ROM burst reader.
package rom_seq_pkg;
   localparam int AW_DEF = 4;
   localparam int DW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_e;
endpackage

// File: rtl/rom_seq_fifo2.sv
// Two-entry output buffer; a push becomes visible one cycle later (no pass-through).
// Pop is combinational on the head entry; a push while full is only accepted together with a pop.
module rom_seq_fifo2
   import rom_seq_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] push_dat_i,
   input  logic          pop_i,
   output logic [DW-1:0] dat_o,
   output logic [1:0]    occ_o
);

   logic [DW-1:0] mem_q [2];
   logic          wr_q;
   logic          rd_q;
   logic [1:0]    occ_q;
   logic          push_ok;
   logic          pop_ok;

   assign pop_ok  = pop_i && (occ_q != 2'd0);
   assign push_ok = push_i && ((occ_q != 2'd2) || pop_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem_q[i] <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         occ_q <= 2'd0;
      end else begin
         if (push_ok) mem_q[wr_q] <= push_dat_i;
         wr_q <= wr_q ^ push_ok;
         rd_q <= rd_q ^ pop_ok;
         case ({push_ok, pop_ok})
            2'b10:   occ_q <= occ_q + 2'd1;
            2'b01:   occ_q <= occ_q - 2'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign dat_o = (occ_q != 2'd0) ? mem_q[rd_q] : '0;
   assign occ_o = occ_q;

endmodule

// File: rtl/rom_seq_reader.sv
// Reads count words from a 1-cycle registered ROM starting at start_addr; first word out 3 cycles after start.
// out_ready backpressure throttles ROM issue so the 2-entry FIFO never overflows. ROM_SEQ_CHECKSUM_EN adds an XOR checksum output.
module rom_seq_reader
   import rom_seq_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   count,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          done
`ifdef ROM_SEQ_CHECKSUM_EN
   ,
   output logic [DW-1:0] checksum
`endif
);

   localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [AW:0]   issued_q, issued_d;
   logic          inflight_q;
   logic          done_q, done_d;
   logic [1:0]    occ;
   logic          pop;
   logic          room;
   logic          issue;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid && out_ready;

   // Words that will sit in the FIFO next cycle must leave room for this cycle's issue.
   assign room = ({1'b0, occ} + {2'b00, inflight_q}) <= ({2'b00, pop} + 3'd1);

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      cnt_d    = cnt_q;
      issued_d = issued_q;
      done_d   = 1'b0;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d   = start_addr;
               cnt_d    = count;
               issued_d = '0;
               state_d  = (count == '0) ? DRAIN : READ;
            end
         end
         READ: begin
            if (room) begin
               issue    = 1'b1;
               issued_d = issued_q + ONE;
               if (issued_d == cnt_q) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         cnt_q      <= '0;
         issued_q   <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         issued_q   <= issued_d;
         inflight_q <= issue;
         done_q     <= done_d;
      end
   end

   assign rom_en   = issue;
   assign rom_addr = issue ? (base_q + issued_q[AW-1:0]) : '0;
   assign busy     = (state_q != IDLE);
   assign done     = done_q;

   rom_seq_fifo2 #(.DW(DW)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (inflight_q),
      .push_dat_i (rom_data),
      .pop_i      (pop),
      .dat_o      (out_data),
      .occ_o      (occ)
   );

`ifdef ROM_SEQ_CHECKSUM_EN
   logic [DW-1:0] csum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else if ((state_q == IDLE) && start) begin
         csum_q <= '0;
      end else if (pop) begin
         csum_q <= csum_q ^ out_data;
      end
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_rom_seq_reader.sv
// Randomized bench for rom_seq_reader against a queue-based burst model and a 16x4 registered ROM.
module tb_rom_seq_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] start_addr = '0;
   logic [4:0] count = '0;
   logic       rom_en;
   logic [3:0] rom_addr;
   logic [3:0] rom_data = '0;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       busy;
   logic       done;
`ifdef ROM_SEQ_CHECKSUM_EN
   logic [3:0] checksum;
`endif

   rom_seq_reader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .count      (count),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
`ifdef ROM_SEQ_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   initial forever #5 clk = ~clk;

   logic [3:0] rom [16];
   int cyc = 0;
   int ntests = 0;
   int nfail = 0;

   // ROM: registered read; garbage on rom_data whenever no read was issued.
   initial forever begin
      @(posedge clk);
      rom_data <= rom_en ? rom[rom_addr] : 4'($urandom);
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
   int rmode = 0;
   int rk = 0;
   logic [3:0] pat = 4'b1001;
   initial forever begin
      @(posedge clk);
      #1;
      case (rmode)
         1: begin out_ready = pat[rk % 4]; rk++; end
         2: out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
   end

   // Monitor state (recorded at negedge; cycle numbers relative to the start edge).
   int t0 = 0;
   logic [3:0] gdat_q [$];
   int         gcyc_q [$];
   logic [3:0] eaddr_q [$];
   int         ecyc_q [$];
   int done_cnt, done_cyc, viol;
   logic busy_at_done, busy_before_done, prev_busy;
   logic [3:0] csum_acc, csum_at_done;
   int mocc = 0, minfl = 0, popi;
   logic stall_prev = 1'b0;
   logic [3:0] prev_data;

   initial forever begin
      @(negedge clk);
      popi = (out_valid === 1'b1 && out_ready === 1'b1) ? 1 : 0;
      if (out_valid !== (mocc != 0)) viol++;
      if (rom_en === 1'b1) begin
         if (mocc + minfl - popi > 1) viol++;
         eaddr_q.push_back(rom_addr);
         ecyc_q.push_back(cyc - t0);
      end
      if (popi == 1) begin
         gdat_q.push_back(out_data);
         gcyc_q.push_back(cyc - t0);
         csum_acc = csum_acc ^ out_data;
      end
      if (stall_prev && (out_valid !== 1'b1 || out_data !== prev_data)) viol++;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc - t0;
         busy_at_done = busy;
         busy_before_done = prev_busy;
`ifdef ROM_SEQ_CHECKSUM_EN
         csum_at_done = checksum;
`else
         csum_at_done = csum_acc;
`endif
      end
      prev_busy  = busy;
      stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
      if (rst) begin
         mocc = 0; minfl = 0; stall_prev = 1'b0;
      end else begin
         mocc = mocc + minfl - popi;
         minfl = (rom_en === 1'b1) ? 1 : 0;
      end
      if (mocc > 2 || mocc < 0) viol++;
   end

   function automatic logic [3:0] exp_word(input int sa, input int i);
      return rom[(sa + i) % 16];
   endfunction

   function automatic int seq_errs(input int sa, input int cnt);
      int e = (gdat_q.size() != cnt) ? 1 : 0;
      for (int i = 0; i < gdat_q.size() && i < cnt; i++)
         if (gdat_q[i] !== exp_word(sa, i)) e++;
      return e;
   endfunction

   function automatic int addr_errs(input int sa, input int cnt);
      int e = (eaddr_q.size() != cnt) ? 1 : 0;
      for (int i = 0; i < eaddr_q.size() && i < cnt; i++)
         if (eaddr_q[i] !== 4'((sa + i) % 16)) e++;
      return e;
   endfunction

   function automatic logic [3:0] exp_xor(input int sa, input int cnt);
      logic [3:0] x = '0;
      for (int i = 0; i < cnt; i++) x ^= exp_word(sa, i);
      return x;
   endfunction

   task automatic clear_mon();
      gdat_q.delete(); gcyc_q.delete(); eaddr_q.delete(); ecyc_q.delete();
      done_cnt = 0; done_cyc = -1; viol = 0; csum_acc = '0;
      busy_at_done = 1'bx; busy_before_done = 1'bx; csum_at_done = 'x;
   endtask

   task automatic start_burst(input int sa, input int cnt);
      clear_mon();
      start_addr = 4'(sa);
      count = 5'(cnt);
      start = 1'b1;
      rk = 0;
      @(posedge clk);
      #1;
      t0 = cyc - 1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (done_cnt > 0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      settle(2);
      ntests++;
      if ({rom_en, rom_addr, out_valid, out_data, busy, done} !== 12'h000) begin
         nfail++;
         $display("FAIL reset_outputs: got %h expected 000", {rom_en, rom_addr, out_valid, out_data, busy, done});
      end
      @(posedge clk); #1; rst = 1'b0;
      settle(2);
      ntests++;
      if ({busy, out_valid, rom_en, done} !== 4'b0000) begin
         nfail++;
         $display("FAIL idle_after_reset: got %b expected 0000", {busy, out_valid, rom_en, done});
      end
   endtask

   task automatic test_basic();
      bit ok; int e;
      rmode = 0;
      start_burst(0, 4);
      wait_done(50, ok);
      settle(3);
      ntests++; if (!ok) begin nfail++; $display("FAIL basic_timeout: no done within 50 cycles"); end
      ntests++; e = seq_errs(0, 4);
      if (e != 0) begin nfail++; $display("FAIL basic_data: %0d bad words (got %0d words, expected 4)", e, gdat_q.size()); end
      ntests++; e = (gcyc_q.size() > 0) ? gcyc_q[0] : -1;
      if (e != 3) begin nfail++; $display("FAIL basic_first_valid: got cycle %0d expected 3", e); end
      ntests++; e = (gcyc_q.size() > 0) ? gcyc_q[gcyc_q.size()-1] : -1;
      if (e != 6) begin nfail++; $display("FAIL basic_last_valid: got cycle %0d expected 6", e); end
      ntests++; e = (ecyc_q.size() > 0) ? ecyc_q[0] : -1;
      if (e != 1) begin nfail++; $display("FAIL basic_first_rom_en: got cycle %0d expected 1", e); end
      ntests++;
      if (done_cyc != 7 || done_cnt != 1) begin
         nfail++; $display("FAIL basic_done: got cycle %0d count %0d expected cycle 7 count 1", done_cyc, done_cnt);
      end
      ntests++;
      if (busy_at_done !== 1'b0 || busy_before_done !== 1'b1) begin
         nfail++; $display("FAIL basic_busy: got %b/%b expected 1/0 (before/at done)", busy_before_done, busy_at_done);
      end
      ntests++; e = addr_errs(0, 4);
      if (e != 0 || viol != 0) begin nfail++; $display("FAIL basic_addr_protocol: got %0d addr errs %0d violations expected 0", e, viol); end
   endtask

   task automatic test_wrap();
      bit ok; int e;
      rmode = 0;
      start_burst(14, 3);
      wait_done(50, ok);
      settle(2);
      ntests++; e = addr_errs(14, 3);
      if (!ok || e != 0) begin nfail++; $display("FAIL wrap_addr: got %0d addr errs (done %0b) expected 0", e, ok); end
      ntests++; e = seq_errs(14, 3);
      if (e != 0) begin nfail++; $display("FAIL wrap_data: got %0d bad words expected 0", e); end
   endtask

   task automatic test_stall();
      bit ok; int e, sa;
      for (int k = 0; k < 2; k++) begin
         rmode = 1;
         sa = $urandom_range(0, 15);
         start_burst(sa, (k == 0) ? 4 : 9);
         wait_done(100, ok);
         settle(2);
         ntests++; e = seq_errs(sa, (k == 0) ? 4 : 9);
         if (!ok || e != 0) begin nfail++; $display("FAIL stall_data: got %0d bad words (done %0b) expected 0", e, ok); end
         ntests++;
         if (viol != 0 || done_cnt != 1) begin
            nfail++; $display("FAIL stall_protocol: got %0d violations %0d dones expected 0 and 1", viol, done_cnt);
         end
      end
      rmode = 0;
   endtask

   task automatic test_zero();
      bit ok;
      rmode = 0;
      start_burst(7, 0);
      wait_done(20, ok);
      settle(3);
      ntests++;
      if (ecyc_q.size() != 0 || gdat_q.size() != 0) begin
         nfail++; $display("FAIL zero_activity: got %0d rom_en %0d words expected 0 and 0", ecyc_q.size(), gdat_q.size());
      end
      ntests++;
      if (!ok || done_cyc != 2 || done_cnt != 1) begin
         nfail++; $display("FAIL zero_done: got cycle %0d count %0d expected cycle 2 count 1", done_cyc, done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit ok; int e;
      rmode = 0;
      start_burst(5, 6);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk); #1;
      ntests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         nfail++; $display("FAIL midrst_state: got valid %b busy %b expected 0 0", out_valid, busy);
      end
      settle(6);
      ntests++;
      if (done_cnt != 0 || gdat_q.size() != 0) begin
         nfail++; $display("FAIL midrst_discard: got %0d dones %0d words expected 0 and 0", done_cnt, gdat_q.size());
      end
      start_burst(9, 5);
      wait_done(50, ok);
      settle(2);
      ntests++; e = seq_errs(9, 5);
      if (!ok || e != 0 || viol != 0) begin
         nfail++; $display("FAIL midrst_reburst: got %0d bad words %0d violations (done %0b) expected 0", e, viol, ok);
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int e;
      rmode = 0;
      clear_mon();
      start_addr = 4'd3; count = 5'd5; start = 1'b1; rk = 0;
      @(posedge clk); #1; t0 = cyc - 1;
      repeat (3) begin
         start_addr = 4'($urandom); count = 5'($urandom);
         @(posedge clk); #1;
      end
      start = 1'b0;
      wait_done(50, ok);
      ntests++; e = seq_errs(3, 5);
      if (!ok || e != 0) begin nfail++; $display("FAIL b2b_ignore_start: got %0d bad words (done %0b) expected 0", e, ok); end
      ntests++;
      if (done_cyc != 8) begin nfail++; $display("FAIL b2b_first_done: got cycle %0d expected 8", done_cyc); end
      start_burst(12, 6);
      wait_done(50, ok);
      settle(2);
      ntests++; e = seq_errs(12, 6);
      if (!ok || e != 0 || viol != 0) begin
         nfail++; $display("FAIL b2b_second: got %0d bad words %0d violations expected 0", e, viol);
      end
      ntests++; e = (gcyc_q.size() > 0) ? gcyc_q[0] : -1;
      if (e != 3 || done_cyc != 9) begin
         nfail++; $display("FAIL b2b_second_timing: got first %0d done %0d expected 3 and 9", e, done_cyc);
      end
   endtask

   task automatic test_random();
      bit ok; int e, sa, cnt, exp_done;
      for (int it = 0; it < 20; it++) begin
         sa = $urandom_range(0, 15);
         cnt = $urandom_range(0, 31);
         rmode = $urandom_range(0, 2);
         start_burst(sa, cnt);
         wait_done(cnt * 6 + 20, ok);
         settle(2);
         ntests++; e = seq_errs(sa, cnt) + addr_errs(sa, cnt);
         if (!ok || e != 0) begin
            nfail++; $display("FAIL rand_seq: sa %0d cnt %0d got %0d errors (done %0b) expected 0", sa, cnt, e, ok);
         end
         ntests++;
         if (viol != 0 || done_cnt != 1) begin
            nfail++; $display("FAIL rand_protocol: got %0d violations %0d dones expected 0 and 1", viol, done_cnt);
         end
         if (rmode == 0) begin
            exp_done = (cnt == 0) ? 2 : cnt + 3;
            ntests++;
            if (done_cyc != exp_done) begin
               nfail++; $display("FAIL rand_throughput: cnt %0d got done cycle %0d expected %0d", cnt, done_cyc, exp_done);
            end
         end
`ifdef ROM_SEQ_CHECKSUM_EN
         ntests++;
         if (csum_at_done !== exp_xor(sa, cnt)) begin
            nfail++; $display("FAIL rand_checksum: got %h expected %h", csum_at_done, exp_xor(sa, cnt));
         end
`endif
      end
      rmode = 0;
   endtask

`ifdef ROM_SEQ_CHECKSUM_EN
   task automatic test_checksum();
      bit ok;
      rmode = 0;
      start_burst(0, 3);
      wait_done(50, ok);
      settle(2);
      ntests++;
      if (!ok || csum_at_done !== 4'hE) begin
         nfail++; $display("FAIL checksum_basic: got %h expected e", csum_at_done);
      end
   endtask
`endif

   initial begin
      rom[0] = 4'h2;  rom[1] = 4'hA;  rom[2] = 4'h6;  rom[3] = 4'h2;
      rom[4] = 4'h7;  rom[5] = 4'h1;  rom[6] = 4'hC;  rom[7] = 4'h9;
      rom[8] = 4'h4;  rom[9] = 4'hF;  rom[10] = 4'h3; rom[11] = 4'h8;
      rom[12] = 4'h5; rom[13] = 4'hB; rom[14] = 4'h2; rom[15] = 4'hE;
      clear_mon();
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_zero();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef ROM_SEQ_CHECKSUM_EN
      test_checksum();
`endif
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
